// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants and FSM state encoding for seq_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default operand width; the product is twice this wide
    localparam int c_DEFAULT_WIDTH = 8;

    // Multiplier control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Shift-add sequential multiplier, one iteration per clock.
//               WIDTH cycles in RUN, then a one-cycle DONE pulse with the
//               registered product. producto only changes on DONE entry.
//               Optional macro SEQ_MULT_SIGNED_EN selects two's-complement
//               operands/result (magnitude multiply plus final negate).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = mult_pkg::c_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   producto
);
    import mult_pkg::*;

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PW-1:0]     r_mcand;    // multiplicand, pre-shifted by iteration index
    logic [c_PW-1:0]     r_acc;
    logic [WIDTH-1:0]    r_mplier;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]    w_a_op;
    logic [WIDTH-1:0]    w_b_op;
    logic [c_PW-1:0]     w_sum;
    logic [c_PW-1:0]     w_result;
    logic                w_last;

    // Accumulator value after the current iteration's conditional add
    assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : {c_PW{1'b0}});
    assign w_last = (r_cnt == c_LAST);

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;

    // Core always works on magnitudes; -2^(W-1) maps to itself as unsigned
    assign w_a_op   = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_b_op   = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign w_result = r_neg ? (~w_sum + 1'b1) : w_sum;

    // Result sign captured alongside the operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign w_a_op   = a;
    assign w_b_op   = b;
    assign w_result = w_sum;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iterations and result load on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            producto <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_op};
                        r_mplier <= w_b_op;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        producto <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier with a result queue.
//               Honours SEQ_MULT_SIGNED_EN for the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int c_W = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [c_W-1:0]  a;
    logic [c_W-1:0]  b;
    logic            busy;
    logic            done;
    logic [2*c_W-1:0] producto;

    int              n_err;
    int              n_chk;
    int              done_count;
    logic [15:0]     exp_disp;
    logic [15:0]     q_exp[$];

    seq_multiplier #(.WIDTH(c_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .producto (producto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MULT_SIGNED_EN
        logic signed [15:0] p;
        p = $signed(x) * $signed(y);
        return p;
`else
        return {8'h00, x} * {8'h00, y};
`endif
    endfunction

    // Scoreboard: pop on each done pulse; while busy the display must hold
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_count++;
                if (q_exp.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    logic [15:0] e;
                    e = q_exp.pop_front();
                    chk("producto", producto, e);
                    exp_disp = e;
                end
            end else if (busy) begin
                chk("hold", producto, exp_disp);
            end
        end
    end

    // Single operation: returns done latency and busy-cycle count from accept edge
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int nbusy);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        q_exp.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) nbusy++;
            if (done && lat < 0) lat = k;
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, nb, d0, t1, t2;
        n_err = 0; n_chk = 0; done_count = 0; exp_disp = 16'h0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_prod", producto, 0);
        rst = 1'b0;

        // 0x0F * 0x0F: latency and busy length
        do_op(8'h0F, 8'h0F, lat, nb);
        chk("lat_0f", lat, 8);
        chk("busy_0f", nb, 9);
        chk("val_e1", producto, 16'h00E1);

`ifdef SEQ_MULT_SIGNED_EN
        do_op(8'hFD, 8'h05, lat, nb);
        chk("val_fff1", producto, 16'hFFF1);
        do_op(8'h80, 8'h80, lat, nb);
        chk("val_4000", producto, 16'h4000);
`else
        do_op(8'hFF, 8'hFF, lat, nb);
        chk("val_fe01", producto, 16'hFE01);
        do_op(8'h00, 8'hA5, lat, nb);
        chk("val_0000", producto, 16'h0000);
`endif

        // start held through RUN, operands changed mid-run, then back-to-back
        d0 = done_count; t1 = -1; t2 = -1;
        @(negedge clk);
        a = 8'h21; b = 8'h43; start = 1'b1;
        q_exp.push_back(model(8'h21, 8'h43));
        @(negedge clk);
        a = 8'h5A; b = 8'h3C;
        q_exp.push_back(model(8'h5A, 8'h3C));
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
            if (t1 >= 0 && k == t1 + 1) chk("gap_idle", busy, 0);
            if (t1 >= 0 && k == t1 + 2) begin
                chk("restart_busy", busy, 1);
                start = 1'b0;
            end
            if (t2 >= 0 && !busy) break;
            @(negedge clk);
        end
        chk("b2b_lat", t1, 8);
        chk("b2b_thr", t2 - t1, 10);
        repeat (12) @(negedge clk);
        chk("b2b_count", done_count - d0, 2);

        // Abort during iteration 4 of 0x12 * 0x34
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        exp_disp = 16'h0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_prod", producto, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_count;
        repeat (15) @(negedge clk);
        chk("abort_nodone", done_count - d0, 0);
        chk("abort_prod2", producto, 16'h0000);

        // Fresh operation after reset, then a few random ones
        do_op(8'h12, 8'h34, lat, nb);
        chk("post_rst_lat", lat, 8);
        for (int i = 0; i < 4; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat, nb);
            chk("rand_lat", lat, 8);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
